// File: rtl/clk_monitor_if.sv
// Signal bundle between the clock monitor and its user: the monitored input,
// the enable, and the measurement results.
`timescale 1ns/1ps
interface clk_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             clk_in;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic [CNT_W:0]   period;
    logic             measure_valid;
    logic             clk_running;
    logic             stuck_high;
    logic [7:0]       meas_count;

    modport slave (
        input  enable, clk_in,
        output high_time, low_time, period, measure_valid,
               clk_running, stuck_high, meas_count
    );

    modport master (
        output enable, clk_in,
        input  high_time, low_time, period, measure_valid,
               clk_running, stuck_high, meas_count
    );
endinterface

// File: rtl/clk_monitor.sv
// Measures high time, low time and period of an asynchronous square wave in
// system-clock cycles, and detects a stopped input via an edge-free timeout.
`timescale 1ns/1ps
module clk_monitor #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    clk_monitor_if.slave mon
);
    typedef enum logic [1:0] {DISABLED, ACQUIRE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic [CNT_W-1:0]       low_time_q, low_time_d;
    logic [CNT_W:0]         period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   running_q, running_d;
    logic                   stuck_q, stuck_d;
    logic [7:0]             meas_cnt_q, meas_cnt_d;

    logic s, rise, fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // s_d follows s continuously so enabling while the input is high sees no edge.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], mon.clk_in};
    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d_q;
    assign fall   = ~s & s_d_q;

    always_comb begin
        state_d     = state_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        high_time_d = high_time_q;
        low_time_d  = low_time_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        running_d   = running_q;
        stuck_d     = stuck_q;
        meas_cnt_d  = meas_cnt_q;

        if (!mon.enable) begin
            state_d    = DISABLED;
            high_cnt_d = '0;
            low_cnt_d  = '0;
            idle_cnt_d = '0;
            running_d  = 1'b0;
            stuck_d    = 1'b0;
        end else if (state_q == DISABLED) begin
            state_d    = ACQUIRE;
            high_cnt_d = '0;
            low_cnt_d  = '0;
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + CNT_ONE;
            if (state_q != ACQUIRE) begin
                if (s) high_cnt_d = sat_inc(high_cnt_q);
                else   low_cnt_d  = sat_inc(low_cnt_q);
            end

            // Edges take precedence over an expiring timeout.
            if (rise) begin
                if (state_q == LOW) begin
                    high_time_d = high_cnt_q;
                    low_time_d  = low_cnt_q;
                    period_d    = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};
                    valid_d     = 1'b1;
                    running_d   = 1'b1;
                    stuck_d     = 1'b0;
                    meas_cnt_d  = meas_cnt_q + 8'd1;
                end
                state_d    = HIGH;
                high_cnt_d = CNT_ONE;
                low_cnt_d  = '0;
                idle_cnt_d = '0;
            end else if (fall) begin
                if (state_q == HIGH) state_d = LOW;
                low_cnt_d  = CNT_ONE;
                idle_cnt_d = '0;
            end else if (idle_cnt_q == TIMEOUT_LAST) begin
                state_d    = ACQUIRE;
                idle_cnt_d = '0;
                running_d  = 1'b0;
                stuck_d    = s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DISABLED;
            sync_q      <= '0;
            s_d_q       <= 1'b0;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            high_time_q <= '0;
            low_time_q  <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            running_q   <= 1'b0;
            stuck_q     <= 1'b0;
            meas_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            s_d_q       <= s;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            high_time_q <= high_time_d;
            low_time_q  <= low_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            running_q   <= running_d;
            stuck_q     <= stuck_d;
            meas_cnt_q  <= meas_cnt_d;
        end
    end

    assign mon.high_time     = high_time_q;
    assign mon.low_time      = low_time_q;
    assign mon.period        = period_q;
    assign mon.measure_valid = valid_q;
    assign mon.clk_running   = running_q;
    assign mon.stuck_high    = stuck_q;
    assign mon.meas_count    = meas_cnt_q;
endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
Receive-side companion to the team's clock generator. Samples an external, asynchronous square wave (clk_in) with the system clock and measures its high time, low time and period in system-clock cycles. Reports a one-cycle measure_valid strobe per completed period and flags a stopped clock (timeout) together with the level it stopped at. Used to verify generator output in-system and gate downstream logic on clk_running.

Parameters:
CNT_W, 16, width of the high/low counters and of the high_time/low_time outputs.
TIMEOUT, 1000, consecutive edge-free system cycles before the input is declared stopped. Constraint: 2 <= TIMEOUT <= 2^CNT_W-1.
SYNC_STAGES, 2, depth of the input synchronizer. Constraint: >= 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  measurement enable. Level sensitive.
clk_in  input  1  monitored signal, asynchronous to clk.
high_time  output  CNT_W  system cycles clk_in was high in the last measured period.
low_time  output  CNT_W  system cycles clk_in was low in the last measured period.
period  output  CNT_W+1  high_time + low_time of the last measured period.
measure_valid  output  1  one-cycle strobe; new high_time/low_time/period are valid.
clk_running  output  1  set on the first measure_valid; cleared on timeout, disable or reset.
stuck_high  output  1  on timeout, the synchronized level at which clk_in stopped.
meas_count  output  8  count of measure_valid strobes; wraps 255->0.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, synchronizer flops 0, counters 0, state DISABLED.
- Synchronizer: SYNC_STAGES flops produce s; one extra flop produces s_d. These flops run regardless of enable. rise = s & ~s_d; fall = ~s & s_d.
- FSM states: DISABLED, ACQUIRE, HIGH, LOW.
  - DISABLED -> ACQUIRE when enable=1. high_cnt, low_cnt and idle_cnt are zeroed on entry.
  - ACQUIRE -> HIGH on rise. No capture on this transition.
  - HIGH -> LOW on fall.
  - LOW -> HIGH on rise. Capture happens on this transition.
  - Any state -> DISABLED when enable=0. This has priority over every other transition.
  - ACQUIRE/HIGH/LOW -> ACQUIRE on timeout.
- Counting, in HIGH/LOW, every cycle:
  - s=1: high_cnt++ ; s=0: low_cnt++.
  - Both counters saturate at 2^CNT_W-1.
  - On rise: high_cnt loads 1 and low_cnt loads 0.
  - On fall: low_cnt loads 1.
- Capture, on the LOW->HIGH edge:
  - high_time <= high_cnt, low_time <= low_cnt, period <= high_cnt+low_cnt (zero-extended, no overflow).
  - measure_valid <= 1 for exactly one cycle; clk_running <= 1; stuck_high <= 0; meas_count++.
  - All of these are registered on the same clk edge that samples rise.
  - Latency from a clk_in rising edge to measure_valid: SYNC_STAGES+1 to SYNC_STAGES+2 cycles.
- Timeout:
  - idle_cnt increments in ACQUIRE/HIGH/LOW and clears on any rise or fall.
  - When TIMEOUT consecutive edge-free cycles have elapsed: clk_running <= 0, stuck_high <= s, state -> ACQUIRE, idle_cnt cleared.
  - Timeout repeats every TIMEOUT cycles while the input stays stuck. stuck_high tracks s at each repeat.
  - Re-acquisition requires two rising edges before the next measure_valid.
- Disable:
  - clk_running <= 0, stuck_high <= 0, measure_valid <= 0, counters cleared.
  - high_time, low_time, period and meas_count hold their last values.
  - A partially measured period is discarded.
- Simultaneous events:
  - enable falling on the same cycle as a capturing rise: disable wins, no strobe.
  - An edge on the same cycle idle_cnt would expire: the edge wins, no timeout.
- Enable rising while s=1: no spurious rise, because s_d runs continuously. Acquisition waits for the next true rising edge.

Test Plan:
1. enable=1; clk_in period 10 cycles (5 high/5 low), driven synchronously to clk -> first measure_valid after the 2nd rise, high_time=5, low_time=5, period=10, clk_running=1; then one strobe every 10 cycles, meas_count incrementing.
2. clk_in 3 high/7 low, then 1 high/1 low -> high_time=3, low_time=7, period=10; then high_time=1, low_time=1, period=2 with a strobe every 2 cycles.
3. TIMEOUT=50; stop clk_in high -> clk_running drops and stuck_high=1 exactly 50 cycles after the last synced edge, with no strobes; resume 5/5 -> no strobe at the 1st rise, strobe at the 2nd rise with period=10 and stuck_high=0.
4. Deassert enable mid-HIGH after 2 valid measurements -> no strobe, clk_running=0, period stays 10 and meas_count stays 2; re-enable -> fresh acquisition needing two rises.
5. Assert rst_n=0 mid-LOW, asynchronously between clk edges -> all outputs 0 immediately; after release with enable=1 -> strobes resume only after two rises and meas_count restarts at 1.
6. Deassert enable on the exact cycle a capturing rise is sampled -> no measure_valid, meas_count unchanged.
